// File: rtl/bounce_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bounce_gen_pkg
// Brief    : Shared types and constants for the bounce generator.
// Revision : 1.0 - initial release
// ============================================================================
package bounce_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDGE   = 2'd1,
    BOUNCE = 2'd2,
    SETTLE = 2'd3
  } state_t;

  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci taps at bits 15,13,12,10
  localparam logic [15:0] c_LFSR_POLY = 16'hB400;

  localparam int c_RAND_W = 4;

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : lfsr16
// Brief    : Free-running 16-bit Fibonacci LFSR, advances every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr16
  import bounce_gen_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state
);

  logic [15:0] r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SEED;
    end else begin
      r_state <= {r_state[14:0], ^(r_state & c_LFSR_POLY)};
    end
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/bounce_gen.sv
`default_nettype none
// ============================================================================
// Module   : bounce_gen
// Brief    : Turns press/release commands into a bouncing button waveform.
//            Define BOUNCE_GEN_RANDOM_EN for LFSR-jittered bounce intervals.
// Revision : 1.0 - initial release
// ============================================================================
module bounce_gen
  import bounce_gen_pkg::*;
#(
  parameter int          BOUNCES        = 3,
  parameter int          BOUNCE_MIN     = 4,
  parameter int          SETTLE_CYCLES  = 20,
  parameter logic [15:0] SEED           = 16'hACE1,
  parameter logic        RELEASED_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic cmd_valid,
  input  logic cmd_level,
  output logic cmd_ready,
  output logic button_out,
  output logic busy,
  output logic done
);

  localparam int c_IW = $clog2(BOUNCE_MIN + 16) + 1;
  localparam int c_TW = $clog2(2 * BOUNCES + 1) + 1;
  localparam int c_SW = $clog2(SETTLE_CYCLES + 1) + 1;

  generate
    if (SEED == 16'h0 || BOUNCE_MIN < 1 || SETTLE_CYCLES < 1) begin : g_bad_params
      $error("bounce_gen: SEED must be nonzero, BOUNCE_MIN and SETTLE_CYCLES >= 1");
    end
  endgenerate

  state_t              r_state;
  state_t              w_next;
  logic                r_button;
  logic                r_done;
  logic [c_IW-1:0]     r_ivl;
  logic [c_TW-1:0]     r_tog;
  logic [c_SW-1:0]     r_set;
  logic [c_RAND_W-1:0] w_rand_ofs;
  logic [c_IW-1:0]     w_interval;
  logic                w_accept;

`ifdef BOUNCE_GEN_RANDOM_EN
  logic [15:0] w_lfsr;

  lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (w_lfsr)
  );

  assign w_rand_ofs = w_lfsr[c_RAND_W-1:0];
`else
  assign w_rand_ofs = '0;
`endif

  assign w_interval = c_IW'(BOUNCE_MIN) + c_IW'(w_rand_ofs);
  assign w_accept   = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && (cmd_level != r_button)) w_next = EDGE;
      EDGE:    w_next = (BOUNCES == 0) ? SETTLE : BOUNCE;
      BOUNCE:  if (r_ivl == c_IW'(1) && r_tog == c_TW'(1)) w_next = SETTLE;
      SETTLE:  if (r_set == c_SW'(1)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = (r_state == IDLE);
    busy       = (r_state != IDLE);
    button_out = r_button;
    done       = r_done;
  end

  // Counters fire on the cycle they read 1, so a load of N spans N edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_button <= RELEASED_LEVEL;
      r_done   <= 1'b0;
      r_ivl    <= '0;
      r_tog    <= '0;
      r_set    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (cmd_level == r_button) r_done <= 1'b1;
            else                       r_button <= cmd_level;
          end
        end
        EDGE: begin
          r_ivl <= w_interval;
          r_tog <= c_TW'(2 * BOUNCES);
          r_set <= c_SW'(SETTLE_CYCLES);
        end
        BOUNCE: begin
          if (r_ivl == c_IW'(1)) begin
            r_button <= ~r_button;
            r_tog    <= r_tog - c_TW'(1);
            r_ivl    <= w_interval;
          end else begin
            r_ivl <= r_ivl - c_IW'(1);
          end
        end
        SETTLE: begin
          if (r_set == c_SW'(1)) r_done <= 1'b1;
          else                   r_set  <= r_set - c_SW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
